// File: rtl/hyper_cfg_seq_pkg.sv
// Shared types and boot-table constants for the HyperBus configuration sequencer.
package hyper_cfg_seq_pkg;

  localparam int unsigned RegAddrWidth     = 48;
  localparam int unsigned RegDataWidth     = 32;
  localparam int unsigned RegStrbWidth     = RegDataWidth / 8;
  localparam int unsigned HypCfgNumEntries = 4;
  localparam int unsigned HypPowerUpCycles = 150;

  typedef struct packed {
    logic [RegAddrWidth-1:0] addr;
    logic                    write;
    logic [RegDataWidth-1:0] wdata;
    logic [RegStrbWidth-1:0] wstrb;
    logic                    valid;
  } hyp_reg_req_t;

  typedef struct packed {
    logic [RegDataWidth-1:0] rdata;
    logic                    error;
    logic                    ready;
  } hyp_reg_rsp_t;

  typedef struct packed {
    logic [RegAddrWidth-1:0] addr;
    logic [RegDataWidth-1:0] data;
  } hyp_cfg_entry_t;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_WRITE = 2'd1,
    ST_PASS  = 2'd2
  } hyp_cfg_state_e;

  // Default boot table: PHY timing, latency, chip-select 0 and 1 config.
  localparam hyp_cfg_entry_t [HypCfgNumEntries-1:0] HypCfgTable = {
    hyp_cfg_entry_t'{addr: 48'h0000_0000_000C, data: 32'h0000_0001},
    hyp_cfg_entry_t'{addr: 48'h0000_0000_0008, data: 32'h0000_0001},
    hyp_cfg_entry_t'{addr: 48'h0000_0000_0004, data: 32'h0000_0006},
    hyp_cfg_entry_t'{addr: 48'h0000_0000_0000, data: 32'h0000_0002}
  };

  function automatic logic [HypCfgNumEntries-1:0][RegAddrWidth-1:0] hyp_cfg_addrs(
    input hyp_cfg_entry_t [HypCfgNumEntries-1:0] tbl
  );
    logic [HypCfgNumEntries-1:0][RegAddrWidth-1:0] res;
    for (int unsigned i = 0; i < HypCfgNumEntries; i++) res[i] = tbl[i].addr;
    return res;
  endfunction

  function automatic logic [HypCfgNumEntries-1:0][RegDataWidth-1:0] hyp_cfg_datas(
    input hyp_cfg_entry_t [HypCfgNumEntries-1:0] tbl
  );
    logic [HypCfgNumEntries-1:0][RegDataWidth-1:0] res;
    for (int unsigned i = 0; i < HypCfgNumEntries; i++) res[i] = tbl[i].data;
    return res;
  endfunction

endpackage

// File: rtl/hyper_cfg_seq.sv
// Boot-time HyperBus config sequencer: waits a power-up delay, writes a fixed
// register table, then passes SoC register traffic straight through.
module hyper_cfg_seq
  import hyper_cfg_seq_pkg::*;
#(
  parameter int unsigned NumEntries    = 4,
  parameter int unsigned PowerUpCycles = 150,
  parameter int unsigned AddrWidth     = RegAddrWidth,
  parameter int unsigned DataWidth     = RegDataWidth,
  parameter logic [NumEntries-1:0][AddrWidth-1:0] CfgAddr = '0,
  parameter logic [NumEntries-1:0][DataWidth-1:0] CfgData = '0,
  parameter type reg_req_t = hyp_reg_req_t,
  parameter type reg_rsp_t = hyp_reg_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     restart_i,
  input  reg_req_t slv_req_i,
  output reg_rsp_t slv_rsp_o,
  output reg_req_t mst_req_o,
  input  reg_rsp_t mst_rsp_i,
  output logic     busy_o,
  output logic     done_o,
  output logic     err_o
);

  localparam int unsigned IdxWidth = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam int unsigned CntWidth = (PowerUpCycles > 1) ? $clog2(PowerUpCycles + 1) : 1;

  hyp_cfg_state_e      state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic                err_q, err_d;
  logic                restart_pend_q, restart_pend_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_WAIT;
      cnt_q          <= '0;
      idx_q          <= '0;
      err_q          <= 1'b0;
      restart_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      err_q          <= err_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    err_d          = err_q;
    restart_pend_d = restart_pend_q;
    mst_req_o      = '0;
    slv_rsp_o      = '0;

    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == CntWidth'(PowerUpCycles - 1)) begin
          state_d = ST_WRITE;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        mst_req_o.valid = 1'b1;
        mst_req_o.write = 1'b1;
        mst_req_o.addr  = CfgAddr[idx_q];
        mst_req_o.wdata = CfgData[idx_q];
        mst_req_o.wstrb = '1;
        if (mst_rsp_i.ready) begin
          if (mst_rsp_i.error) err_d = 1'b1;
          if (idx_q == IdxWidth'(NumEntries - 1)) state_d = ST_PASS;
          else                                     idx_d   = idx_q + 1'b1;
        end
      end
      ST_PASS: begin
        mst_req_o = slv_req_i;
        slv_rsp_o = mst_rsp_i;
        // A restart never cuts an in-flight SoC transfer; it waits for an idle cycle.
        if (!slv_req_i.valid && (restart_i || restart_pend_q)) begin
          state_d        = ST_WAIT;
          cnt_d          = '0;
          restart_pend_d = 1'b0;
        end else if (restart_i) begin
          restart_pend_d = 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Requests drop in the very cycle reset is applied; the target shares this reset.
    if (rst_i) begin
      mst_req_o = '0;
      slv_rsp_o = '0;
    end
  end

  assign busy_o = (state_q != ST_PASS);
  assign done_o = (state_q == ST_PASS);
  assign err_o  = err_q;

endmodule

// File: tb/tb_hyper_cfg_seq.sv
// Directed self-checking bench for hyper_cfg_seq with a 3-entry table and 10-cycle power-up.
module tb_hyper_cfg_seq;
  import hyper_cfg_seq_pkg::*;

  localparam int unsigned P = 10;
  localparam int unsigned N = 3;
  localparam logic [N-1:0][47:0] TbAddr = {48'h0000_0000_0018, 48'h0000_0000_0014, 48'h0000_0000_0010};
  localparam logic [N-1:0][31:0] TbData = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         restart_i = 1'b0;
  hyp_reg_req_t slv_req = '0;
  hyp_reg_rsp_t slv_rsp;
  hyp_reg_req_t mst_req;
  hyp_reg_rsp_t mst_rsp = '0;
  logic         busy, done, err;

  int total = 0;
  int bad   = 0;

  logic [47:0] exp_addr [N] = '{48'h10, 48'h14, 48'h18};
  logic [31:0] exp_data [N] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

  hyper_cfg_seq #(
    .NumEntries   (N),
    .PowerUpCycles(P),
    .AddrWidth    (48),
    .DataWidth    (32),
    .CfgAddr      (TbAddr),
    .CfgData      (TbData)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .restart_i(restart_i),
    .slv_req_i(slv_req),
    .slv_rsp_o(slv_rsp),
    .mst_req_o(mst_req),
    .mst_rsp_i(mst_rsp),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0 (first cycle with rst_i low), inputs idle.
  task automatic do_reset();
    slv_req = '0;
    mst_rsp = '0;
    mst_rsp.ready = 1'b1;
    restart_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
  endtask

  // Checks a full boot from cycle 0 of WAIT, target ready held high.
  task automatic check_boot_seq(input string tag);
    for (int c = 0; c < int'(P); c++) begin
      total++;
      if (mst_req.valid !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s wait c%0d valid=%b busy=%b required valid=0 busy=1", tag, c, mst_req.valid, busy);
      end
      step();
    end
    for (int e = 0; e < int'(N); e++) begin
      total++;
      if (mst_req.valid !== 1'b1 || mst_req.write !== 1'b1 || mst_req.addr !== exp_addr[e] ||
          mst_req.wdata !== exp_data[e] || mst_req.wstrb !== 4'hF) begin
        bad++;
        $display("FAIL %s entry%0d v=%b w=%b addr=%h data=%h strb=%h required addr=%h data=%h",
                 tag, e, mst_req.valid, mst_req.write, mst_req.addr, mst_req.wdata, mst_req.wstrb,
                 exp_addr[e], exp_data[e]);
      end
      step();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s done done=%b busy=%b required done=1 busy=0", tag, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    mst_rsp = '0;
    mst_rsp.ready = 1'b1;
    slv_req = '0;
    slv_req.valid = 1'b1;
    step();
    total++;
    if (mst_req !== '0 || slv_rsp !== '0 || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold req=%h rsp=%h busy=%b done=%b err=%b required all zero busy=1",
               mst_req, slv_rsp, busy, done, err);
    end
    slv_req = '0;
    rst_i = 1'b0;
    #1;
    total++;
    if (mst_req !== '0 || slv_rsp !== '0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_after req=%h rsp=%h busy=%b done=%b required zero busy=1 done=0",
               mst_req, slv_rsp, busy, done);
    end
  endtask

  task automatic test_boot();
    do_reset();
    check_boot_seq("boot");
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < int'(P) + 1; c++) step();
    mst_rsp.ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (mst_req.valid !== 1'b1 || mst_req.addr !== exp_addr[1] || mst_req.wdata !== exp_data[1]) begin
        bad++;
        $display("FAIL bp_stable c%0d valid=%b addr=%h data=%h required addr=%h data=%h",
                 c, mst_req.valid, mst_req.addr, mst_req.wdata, exp_addr[1], exp_data[1]);
      end
      step();
    end
    mst_rsp.ready = 1'b1;
    #1;
    step();
    total++;
    if (mst_req.valid !== 1'b1 || mst_req.addr !== exp_addr[2]) begin
      bad++;
      $display("FAIL bp_next valid=%b addr=%h required valid=1 addr=%h", mst_req.valid, mst_req.addr, exp_addr[2]);
    end
    step();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL bp_done at cycle 18 done=%b required 1", done);
    end
  endtask

  task automatic test_soc_stall();
    do_reset();
    mst_rsp.rdata = 32'hCAFE_0001;
    step();
    step();
    slv_req.valid = 1'b1;
    slv_req.write = 1'b0;
    slv_req.addr  = 48'h100;
    #1;
    for (int c = 2; c < int'(P + N); c++) begin
      total++;
      if (slv_rsp !== '0) begin
        bad++;
        $display("FAIL stall c%0d slv_rsp=%h required 0", c, slv_rsp);
      end
      step();
    end
    total++;
    if (slv_rsp.ready !== 1'b1 || slv_rsp.rdata !== 32'hCAFE_0001 || mst_req.valid !== 1'b1 ||
        mst_req.addr !== 48'h100 || mst_req.write !== 1'b0) begin
      bad++;
      $display("FAIL stall_pass rdy=%b rdata=%h mvalid=%b maddr=%h required rdy=1 rdata=cafe0001 maddr=100",
               slv_rsp.ready, slv_rsp.rdata, mst_req.valid, mst_req.addr);
    end
    mst_rsp.rdata = 32'hCAFE_0002;
    #1;
    total++;
    if (slv_rsp.rdata !== 32'hCAFE_0002) begin
      bad++;
      $display("FAIL pass_comb rdata=%h required cafe0002", slv_rsp.rdata);
    end
    slv_req = '0;
  endtask

  task automatic test_error_flag();
    do_reset();
    for (int c = 0; c < int'(P); c++) step();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_pre err=%b required 0", err);
    end
    mst_rsp.error = 1'b1;
    #1;
    step();
    mst_rsp.error = 1'b0;
    #1;
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_set err=%b required 1", err);
    end
    step();
    step();
    total++;
    if (done !== 1'b1 || err !== 1'b1) begin
      bad++;
      $display("FAIL err_complete done=%b err=%b required 1 1", done, err);
    end
    restart_i = 1'b1;
    #1;
    step();
    restart_i = 1'b0;
    #1;
    total++;
    if (busy !== 1'b1 || err !== 1'b1) begin
      bad++;
      $display("FAIL err_restart busy=%b err=%b required 1 1", busy, err);
    end
    check_boot_seq("err_rerun");
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky err=%b required 1", err);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear err=%b required 0", err);
    end
  endtask

  task automatic test_restart_during_soc();
    do_reset();
    check_boot_seq("pre_restart");
    slv_req.valid = 1'b1;
    slv_req.write = 1'b1;
    slv_req.addr  = 48'h200;
    slv_req.wdata = 32'h0000_0055;
    slv_req.wstrb = 4'hF;
    mst_rsp.ready = 1'b0;
    restart_i = 1'b1;
    #1;
    total++;
    if (mst_req.valid !== 1'b1 || mst_req.addr !== 48'h200 || slv_rsp.ready !== 1'b0) begin
      bad++;
      $display("FAIL rs_pass mvalid=%b maddr=%h srdy=%b required 1 200 0", mst_req.valid, mst_req.addr, slv_rsp.ready);
    end
    step();
    restart_i = 1'b0;
    #1;
    total++;
    if (done !== 1'b1 || mst_req.wdata !== 32'h55) begin
      bad++;
      $display("FAIL rs_pending done=%b wdata=%h required 1 55", done, mst_req.wdata);
    end
    mst_rsp.ready = 1'b1;
    #1;
    total++;
    if (slv_rsp.ready !== 1'b1) begin
      bad++;
      $display("FAIL rs_handshake srdy=%b required 1", slv_rsp.ready);
    end
    step();
    slv_req = '0;
    #1;
    step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rs_busy busy=%b required 1", busy);
    end
    check_boot_seq("rs_rerun");
  endtask

  task automatic test_reset_mid_seq();
    do_reset();
    for (int c = 0; c < int'(P) + 1; c++) step();
    mst_rsp.ready = 1'b0;
    #1;
    total++;
    if (mst_req.valid !== 1'b1 || mst_req.addr !== exp_addr[1]) begin
      bad++;
      $display("FAIL mid_entry1 valid=%b addr=%h required 1 %h", mst_req.valid, mst_req.addr, exp_addr[1]);
    end
    step();
    rst_i = 1'b1;
    step();
    total++;
    if (mst_req.valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_drop valid=%b busy=%b required 0 1", mst_req.valid, busy);
    end
    rst_i = 1'b0;
    mst_rsp.ready = 1'b1;
    #1;
    check_boot_seq("mid_reboot");
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_soc_stall();
    test_error_flag();
    test_restart_during_soc();
    test_reset_mid_seq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
